fc_layer_link: RTL and testbench

Inter-layer link between two consecutive `fc_layer` instances of the MLP pipeline. It collects the activation stream produced by layer N's function unit into a ping-pong staging buffer. When layer N+1 is idle, it copies a complete vector into layer N+1's input buffer and issues layer N+1's start pulse. Two banks let layer N produce vector k+1 while vector k waits for, or is being copied into, layer N+1.

---
 rtl/fc_layer_link.sv | 121 ++++++++++++
 tb/tb_fc_layer_link.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_link.sv
// Inter-layer link: ping-pong staging of layer N activations and
// block copy into layer N+1's input buffer followed by a start pulse.
module fc_layer_link #(
    parameter int datatype_size = 2,
    parameter int vector_size   = 500,
    parameter int addr_width    = $clog2(vector_size)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic [datatype_size-1:0] i_data,
    output logic                     o_busy,
    output logic                     o_overflow,
    output logic                     o_ibuf_we,
    output logic [addr_width-1:0]    o_ibuf_addr,
    output logic [datatype_size-1:0] o_ibuf_wr_data,
    output logic                     o_start,
    input  logic                     i_next_busy
);

    typedef enum logic [1:0] {IDLE, COPY, START, WAIT_ACK} state_t;

    localparam logic [addr_width-1:0] last = addr_width'(vector_size - 1);

    logic [datatype_size-1:0] mem [2][vector_size];
    logic [1:0]               full;
    logic [1:0]               set_mask;
    logic [1:0]               clr_mask;
    logic                     fill_bank;
    logic                     rd_bank;
    logic [addr_width-1:0]    wr_cnt;
    logic [addr_width-1:0]    rd_cnt;
    logic                     accept;
    state_t                   state;

    assign o_busy = full[fill_bank];
    assign accept = i_valid && !full[fill_bank];

    // The bank is released with the start pulse, so o_busy drops
    // in the same cycle o_start is high.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        set_mask[fill_bank] = accept && (wr_cnt == last);
        clr_mask[rd_bank] = (state == START);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[fill_bank][wr_cnt] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full       <= '0;
            fill_bank  <= 1'b0;
            wr_cnt     <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (i_valid && full[fill_bank]) begin
                o_overflow <= 1'b1;
            end
            if (accept) begin
                if (wr_cnt == last) begin
                    wr_cnt    <= '0;
                    fill_bank <= ~fill_bank;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            full <= (full | set_mask) & ~clr_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            rd_bank        <= 1'b0;
            rd_cnt         <= '0;
            o_ibuf_we      <= 1'b0;
            o_ibuf_addr    <= '0;
            o_ibuf_wr_data <= '0;
            o_start        <= 1'b0;
        end else begin
            o_ibuf_we <= 1'b0;
            o_start   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (full[rd_bank] && !i_next_busy) begin
                        state  <= COPY;
                        rd_cnt <= '0;
                    end
                end
                COPY: begin
                    o_ibuf_we      <= 1'b1;
                    o_ibuf_addr    <= rd_cnt;
                    o_ibuf_wr_data <= mem[rd_bank][rd_cnt];
                    if (rd_cnt == last) begin
                        rd_cnt <= '0;
                        state  <= START;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                START: begin
                    o_start <= 1'b1;
                    state   <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (i_next_busy) begin
                        rd_bank <= ~rd_bank;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_link.sv
// Bench for fc_layer_link: small (4) and default (500) vector instances,
// vector-level reference model, scoreboard queues and a layer N+1 model.
module tb_fc_layer_link;

    logic       clk;
    logic       rst;
    logic       vld  [2];
    logic [1:0] din  [2];
    logic       nb   [2];
    logic       busy [2];
    logic       ovf  [2];
    logic       we   [2];
    logic       st   [2];
    logic [1:0] wd   [2];
    logic [8:0] wa   [2];
    logic [1:0] a4;
    logic [8:0] a5;

    assign wa[0] = {7'd0, a4};
    assign wa[1] = a5;

    fc_layer_link #(.datatype_size(2), .vector_size(4)) dut4 (
        .clk(clk), .rst(rst),
        .i_valid(vld[0]), .i_data(din[0]),
        .o_busy(busy[0]), .o_overflow(ovf[0]),
        .o_ibuf_we(we[0]), .o_ibuf_addr(a4),
        .o_ibuf_wr_data(wd[0]), .o_start(st[0]),
        .i_next_busy(nb[0])
    );

    fc_layer_link #(.datatype_size(2)) dut500 (
        .clk(clk), .rst(rst),
        .i_valid(vld[1]), .i_data(din[1]),
        .o_busy(busy[1]), .o_overflow(ovf[1]),
        .o_ibuf_we(we[1]), .o_ibuf_addr(a5),
        .o_ibuf_wr_data(wd[1]), .o_start(st[1]),
        .i_next_busy(nb[1])
    );

    int tests;
    int fails;
    int cyc;
    int expq [2][$];
    int part [2];
    int fullcnt [2];
    int wcnt [2];
    int last_acc [2];
    int last_we [2];
    int last_st [2];
    int ack_done [2];
    int dly [2];
    int len [2];
    int mon_e;
    logic [8:0] last_wa [2];
    bit movf [2];
    bit chk_lat [2];
    bit hold [2];
    bit lbusy [2];
    bit ack_pend [2];
    bit st_seen [2];

    function automatic int vs(input int k);
        return (k == 0) ? 4 : 500;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)",
                     nm, act, req, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        tests++;
        fails++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    task automatic put(input int k, input int d);
        @(negedge clk);
        #1;
        vld[k] = 1'b1;
        din[k] = 2'(d);
        if (fullcnt[k] < 2) begin
            expq[k].push_back(part[k] * 4 + d);
            part[k]++;
            if (part[k] == vs(k)) begin
                part[k] = 0;
                fullcnt[k]++;
                last_acc[k] = cyc + 1;
            end
        end else begin
            movf[k] = 1'b1;
        end
    endtask

    task automatic idle(input int k, input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            vld[k] = 1'b0;
        end
    endtask

    task automatic wait_drain(input int k, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            #2;
            done = expq[k].size() == 0 && fullcnt[k] == 0 &&
                   part[k] == 0 && !ack_pend[k] && !nb[k];
        end
        if (!done) fail_now("drain_timeout");
    endtask

    task automatic chk_reset(input int k);
        chk("rst_we", we[k], 0);
        chk("rst_addr", wa[k], 0);
        chk("rst_data", wd[k], 0);
        chk("rst_start", st[k], 0);
        chk("rst_busy", busy[k], 0);
        chk("rst_overflow", ovf[k], 0);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            expq[k].delete();
            part[k] = 0;
            fullcnt[k] = 0;
            movf[k] = 1'b0;
            chk_lat[k] = 1'b0;
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Layer N+1: goes busy a little after each start, then idles.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    lbusy[k] = 1'b0;
                    ack_pend[k] = 1'b0;
                end else begin
                    if (st[k]) begin
                        ack_pend[k] = 1'b1;
                        dly[k] = $urandom_range(0, 3);
                        len[k] = $urandom_range(2, 5);
                    end
                    if (ack_pend[k]) begin
                        if (dly[k] > 0) begin
                            dly[k]--;
                        end else if (len[k] > 0) begin
                            lbusy[k] = 1'b1;
                            len[k]--;
                        end else begin
                            lbusy[k] = 1'b0;
                            ack_pend[k] = 1'b0;
                            ack_done[k] = cyc;
                        end
                    end
                end
                nb[k] = hold[k] | lbusy[k];
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    wcnt[k] = 0;
                    st_seen[k] = 1'b0;
                end else begin
                    if (st[k]) begin
                        fullcnt[k]--;
                        chk("start_wr_count", wcnt[k], vs(k));
                        chk("start_after_last_wr", cyc, last_we[k] + 1);
                        chk("start_last_addr", last_wa[k], vs(k) - 1);
                        chk("busy_low_at_start", busy[k], 0);
                        if (st_seen[k])
                            chk("start_gap", int'(cyc - last_st[k] >= vs(k) + 2), 1);
                        st_seen[k] = 1'b1;
                        last_st[k] = cyc;
                        wcnt[k] = 0;
                    end
                    if (we[k]) begin
                        if (wcnt[k] == 0) begin
                            if (chk_lat[k]) begin
                                chk("first_wr_latency", cyc, last_acc[k] + 2);
                                chk_lat[k] = 1'b0;
                            end
                            if (st_seen[k])
                                chk("ack_before_copy", int'(ack_done[k] > last_st[k]), 1);
                        end
                        if (expq[k].size() == 0) begin
                            fail_now("unexpected_write");
                        end else begin
                            mon_e = expq[k].pop_front();
                            chk("wr_addr", wa[k], mon_e / 4);
                            chk("wr_data", wd[k], mon_e % 4);
                        end
                        wcnt[k]++;
                        last_we[k] = cyc;
                        last_wa[k] = wa[k];
                    end
                    chk("busy", busy[k], int'(fullcnt[k] == 2));
                    chk("overflow", ovf[k], movf[k]);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        tests = 0;
        fails = 0;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vld[k] = 1'b0;
            din[k] = 2'd0;
            hold[k] = 1'b0;
            lbusy[k] = 1'b0;
            ack_pend[k] = 1'b0;
            st_seen[k] = 1'b0;
            ack_done[k] = -1;
            last_st[k] = -1;
            last_we[k] = -1;
            last_wa[k] = '0;
            wcnt[k] = 0;
        end
        model_reset();
        #1 rst = 1'b1;
        #2;
        chk_reset(0);
        chk_reset(1);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        // single vector 3,1,2,0
        chk_lat[0] = 1'b1;
        put(0, 3); put(0, 1); put(0, 2); put(0, 0);
        idle(0, 1);
        wait_drain(0, 100);

        // second vector streams in while the first is copied
        put(0, 0); put(0, 1); put(0, 2); put(0, 3);
        idle(0, 2);
        for (int i = 0; i < 4; i++) put(0, $urandom_range(0, 3));
        idle(0, 1);
        wait_drain(0, 100);
        chk("overlap_overflow", ovf[0], 0);

        // gapped input, one element every third cycle
        chk_lat[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            put(0, $urandom_range(0, 3));
            idle(0, 2);
        end
        wait_drain(0, 100);

        // back-pressure: 12 elements while layer N+1 is busy
        hold[0] = 1'b1;
        idle(0, 2);
        for (int i = 0; i < 12; i++) put(0, $urandom_range(0, 3));
        idle(0, 3);
        #2;
        chk("bp_busy", busy[0], 1);
        chk("bp_overflow", ovf[0], 1);
        chk("bp_no_copy", we[0], 0);
        chk("bp_model_full", fullcnt[0], 2);
        hold[0] = 1'b0;
        wait_drain(0, 200);

        // reset in the middle of a copy
        for (int i = 0; i < 4; i++) put(0, $urandom_range(0, 3));
        idle(0, 1);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            #2;
            got = we[0] && wa[0] == 9'd1;
        end
        if (!got) fail_now("rst_copy_wait_timeout");
        #1 rst = 1'b1;
        #1;
        chk_reset(0);
        model_reset();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        chk_lat[0] = 1'b1;
        for (int i = 0; i < 4; i++) put(0, 1);
        idle(0, 1);
        wait_drain(0, 100);
        chk("post_rst_overflow", ovf[0], 0);

        // randomized traffic with random layer N+1 latency
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 9) < 7) put(0, $urandom_range(0, 3));
            else idle(0, 1);
        end
        for (int i = 0; i < 200 && part[0] != 0; i++)
            put(0, $urandom_range(0, 3));
        idle(0, 1);
        wait_drain(0, 400);

        // default size: two back-to-back ramp vectors
        chk_lat[1] = 1'b1;
        for (int i = 0; i < 1000; i++) put(1, i % 4);
        idle(1, 1);
        wait_drain(1, 3000);
        chk("default_overflow", ovf[1], 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
